// File: rtl/sp_bank_switch_ctrl.sv
// Mode-switch sequencer for the banked stack pointers: saves R13 into the
// outgoing bank, updates M, reloads R13 from the incoming bank.
module sp_bank_switch_ctrl #(
    parameter logic [4:0] RESET_MODE = 5'b10011,
    parameter int         DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [4:0]    new_mode,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [DW-1:0] sp_rf_rd,
    output logic          rf_sp_we,
    output logic [DW-1:0] rf_sp_wdata,
    output logic [4:0]    M,
    output logic          SP_out,
    output logic          SP_in,
    output logic [DW-1:0] SP,
    input  logic [DW-1:0] SP_tmp
);

    typedef enum logic [1:0] {IDLE, SAVE, LOAD, WB} state_t;

    localparam int NLEGAL = 9;
    localparam logic [NLEGAL-1:0][3:0] LEGAL_LO =
        {4'hF, 4'hB, 4'hA, 4'h7, 4'h6, 4'h3, 4'h2, 4'h1, 4'h0};

    state_t          state_reg, state_next;
    logic [4:0]      m_reg, m_next;
    logic [4:0]      nm_reg, nm_next;
    logic [DW-1:0]   sp_reg, sp_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic [NLEGAL-1:0] lo_hit;
    logic            mode_legal;
    logic            same_bank;

    genvar gi;
    generate
        for (gi = 0; gi < NLEGAL; gi++) begin : g_legal
            assign lo_hit[gi] = (new_mode[3:0] == LEGAL_LO[gi]);
        end
    endgenerate

    assign mode_legal = new_mode[4] & (|lo_hit);
    // Low nibble zero is the only mode that banks to PSP.
    assign same_bank  = ((new_mode[3:0] == 4'h0) == (m_reg[3:0] == 4'h0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            m_reg     <= RESET_MODE;
            nm_reg    <= RESET_MODE;
            sp_reg    <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            nm_reg    <= nm_next;
            sp_reg    <= sp_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        nm_next    = nm_reg;
        sp_next    = sp_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    nm_next = new_mode;
                    if (!mode_legal) begin
                        err_next = 1'b1;
                    end else if (same_bank) begin
                        m_next    = new_mode;
                        done_next = 1'b1;
                    end else begin
                        state_next = SAVE;
                    end
                end
            end
            SAVE: begin
                sp_next    = sp_rf_rd;
                m_next     = nm_reg;
                state_next = LOAD;
            end
            LOAD:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign SP_out      = (state_reg == SAVE);
    assign SP_in       = (state_reg == LOAD);
    assign rf_sp_we    = (state_reg == WB);
    // SP follows R13 live during SAVE so the store captures it that cycle.
    assign SP          = SP_out ? sp_rf_rd : sp_reg;
    assign rf_sp_wdata = rf_sp_we ? SP_tmp : '0;
    assign done        = done_reg | rf_sp_we;
    assign err         = err_reg;
    assign M           = m_reg;

endmodule
